// File: rtl/dcache_refill_writer_if.sv
// rtl/dcache_refill_writer_if.sv - command, beat, array-write and completion signals of the refill writer
interface dcache_refill_writer_if #(
    parameter int BANK      = 8,
    parameter int BANK_BITS = 32,
    parameter int WAY       = 4,
    parameter int SET_WIDTH = 6,
    parameter int TAG       = 20,
    parameter int BUS_BITS  = 64
);
    localparam int BYTE = BANK_BITS / 8;

    logic                          req_valid;
    logic                          req_ready;
    logic [WAY-1:0]                req_way;
    logic [SET_WIDTH-1:0]          req_index;
    logic [TAG-1:0]                req_tag;
    logic                          req_dirty;

    logic                          beat_valid;
    logic                          beat_ready;
    logic [BUS_BITS-1:0]           beat_data;

    logic                          arr_req;
    logic                          arr_grant;
    logic [WAY-1:0]                tag_we;
    logic [WAY-1:0]                meta_we;
    logic [SET_WIDTH-1:0]          tagv_windex;
    logic [SET_WIDTH-1:0]          meta_windex;
    logic [TAG-1:0]                tag_wdata;
    logic                          wmeta_v;
    logic                          wmeta_dirty;
    logic [BANK-1:0]               bank_en;
    logic [BANK*WAY*BYTE-1:0]      bank_we;
    logic [BANK*SET_WIDTH-1:0]     bank_index;
    logic [BANK*BANK_BITS-1:0]     bank_wdata;

    logic                          done_valid;
    logic [SET_WIDTH-1:0]          done_index;
    logic [WAY-1:0]                done_way;

    modport master (
        output req_valid, req_way, req_index, req_tag, req_dirty,
        output beat_valid, beat_data, arr_grant,
        input  req_ready, beat_ready, arr_req,
        input  tag_we, meta_we, tagv_windex, meta_windex, tag_wdata, wmeta_v, wmeta_dirty,
        input  bank_en, bank_we, bank_index, bank_wdata,
        input  done_valid, done_index, done_way
    );

    modport slave (
        input  req_valid, req_way, req_index, req_tag, req_dirty,
        input  beat_valid, beat_data, arr_grant,
        output req_ready, beat_ready, arr_req,
        output tag_we, meta_we, tagv_windex, meta_windex, tag_wdata, wmeta_v, wmeta_dirty,
        output bank_en, bank_we, bank_index, bank_wdata,
        output done_valid, done_index, done_way
    );
endinterface

// File: rtl/dcache_refill_writer.sv
// rtl/dcache_refill_writer.sv - collects refill beats into a line buffer and installs the line in one granted write cycle
module dcache_refill_writer #(
    parameter int BANK      = 8,
    parameter int BANK_BITS = 32,
    parameter int WAY       = 4,
    parameter int SET_WIDTH = 6,
    parameter int TAG       = 20,
    parameter int BUS_BITS  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    dcache_refill_writer_if.slave bus
);
    localparam int BYTE      = BANK_BITS / 8;
    localparam int LINE_BITS = BANK * BANK_BITS;
    localparam int BEATS     = LINE_BITS / BUS_BITS;
    localparam int CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        REQ,
        DONE
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [CNT_W-1:0]       cnt;
    logic [WAY-1:0]         lat_way;
    logic [SET_WIDTH-1:0]   lat_index;
    logic [TAG-1:0]         lat_tag;
    logic                   lat_dirty;
    logic [LINE_BITS-1:0]   line_buf;

    logic                   accept_req;
    logic                   accept_beat;
    logic                   last_beat;
    logic                   write_fire;

    assign accept_req  = (state == IDLE) && bus.req_valid;
    assign accept_beat = (state == FILL) && bus.beat_valid;
    assign last_beat   = (cnt == CNT_W'(BEATS - 1));

    always_comb begin
        state_next     = state;
        bus.req_ready  = 1'b0;
        bus.beat_ready = 1'b0;
        bus.arr_req    = 1'b0;
        bus.done_valid = 1'b0;
        write_fire     = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                bus.beat_ready = 1'b1;
                if (bus.beat_valid && last_beat) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                bus.arr_req = 1'b1;
                if (bus.arr_grant) begin
                    write_fire = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                bus.done_valid = 1'b1;
                state_next     = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_way   <= '0;
            lat_index <= '0;
            lat_tag   <= '0;
            lat_dirty <= 1'b0;
        end else begin
            state <= state_next;
            if (accept_req) begin
                lat_way   <= bus.req_way;
                lat_index <= bus.req_index;
                lat_tag   <= bus.req_tag;
                lat_dirty <= bus.req_dirty;
                cnt       <= '0;
            end else if (accept_beat) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Line data needs no reset: it is only ever read after a full set of beats has overwritten it.
    always_ff @(posedge clk) begin
        if (accept_beat) begin
            line_buf[cnt*BUS_BITS +: BUS_BITS] <= bus.beat_data;
        end
    end

    assign bus.tag_we      = write_fire ? lat_way : '0;
    assign bus.meta_we     = write_fire ? lat_way : '0;
    assign bus.tagv_windex = write_fire ? lat_index : '0;
    assign bus.meta_windex = write_fire ? lat_index : '0;
    assign bus.tag_wdata   = write_fire ? lat_tag : '0;
    assign bus.wmeta_v     = write_fire;
    assign bus.wmeta_dirty = write_fire & lat_dirty;
    assign bus.bank_en     = {BANK{write_fire}};

    for (genvar b = 0; b < BANK; b++) begin : g_bank
        assign bus.bank_index[b*SET_WIDTH +: SET_WIDTH] = write_fire ? lat_index : '0;
        assign bus.bank_wdata[b*BANK_BITS +: BANK_BITS] =
            write_fire ? line_buf[b*BANK_BITS +: BANK_BITS] : '0;
        for (genvar w = 0; w < WAY; w++) begin : g_way
            assign bus.bank_we[(b*WAY + w)*BYTE +: BYTE] = {BYTE{write_fire & lat_way[w]}};
        end
    end

    assign bus.done_index = (state == DONE) ? lat_index : '0;
    assign bus.done_way   = (state == DONE) ? lat_way : '0;
endmodule
